// File: rtl/word_rle_sink.sv
// rtl/word_rle_sink.sv - run-length encoder of an 8-bit word stream into {len, word} records
// Records queue in a small FIFO; a push that finds the FIFO full is dropped and flagged.

module word_rle_sink_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] s_tdata,
  input  logic        s_tvalid,
  output logic [15:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        overflow
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL    = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   OCC_ONE = (AW + 1)'(1);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic          pop;
  logic          accept;

  assign m_tvalid = (occ != '0);
  assign pop      = m_tvalid && m_tready;
  // A full FIFO still takes a record when the head leaves on the same edge.
  assign accept   = s_tvalid && ((occ != FULL) || pop);
  assign m_tdata  = m_tvalid ? mem[rd_ptr] : 16'h0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
      case ({accept, pop})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
      if (s_tvalid && !accept) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= s_tdata;
  end
endmodule

module word_rle_sink #(
  parameter int DEPTH   = 4,
  parameter int MAX_RUN = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  __in0,
  input  logic        __in1,
  input  logic        __in2,
  input  logic        __in3,
  output logic [15:0] __out0,
  output logic        __out1,
  output logic        __out2
);
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_RUN);

  state_t      state;
  logic [7:0]  cur;
  logic [7:0]  cnt;
  logic        push;

  // The open run closes on flush, on a different word, or when it reaches MAX_RUN.
  always_comb begin
    push = 1'b0;
    if (state == RUN) begin
      if (__in2)
        push = 1'b1;
      else if (__in1 && ((__in0 != cur) || (cnt == MAX_CNT)))
        push = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cur   <= 8'h00;
      cnt   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (__in1) begin
            state <= RUN;
            cur   <= __in0;
            cnt   <= 8'd1;
          end
        end
        RUN: begin
          if (__in1) begin
            if (push) begin
              cur <= __in0;
              cnt <= 8'd1;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end else if (__in2) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  word_rle_sink_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  ({cnt, cur}),
    .s_tvalid (push),
    .m_tdata  (__out0),
    .m_tvalid (__out1),
    .m_tready (__in3),
    .overflow (__out2)
  );
endmodule

// File: tb/tb_word_rle_sink.sv
// tb/tb_word_rle_sink.sv - directed self-checking bench for word_rle_sink

module tb_word_rle_sink;
  logic        clk;
  logic        rst;
  logic [7:0]  in0;
  logic        in1;
  logic        in2;
  logic        in3;
  logic [15:0] out0;
  logic        out1;
  logic        out2;

  int n_checks;
  int n_errors;

  word_rle_sink #(
    .DEPTH   (4),
    .MAX_RUN (255)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .__in0  (in0),
    .__in1  (in1),
    .__in2  (in2),
    .__in3  (in3),
    .__out0 (out0),
    .__out1 (out1),
    .__out2 (out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic e, input logic [7:0] w, input logic f, input logic r);
    in1 = e;
    in0 = w;
    in2 = f;
    in3 = r;
    @(posedge clk);
    #1;
  endtask

  task automatic pop_expect(input string tag, input logic [15:0] exp);
    check({tag, "_valid"}, {15'd0, out1}, 16'h0001);
    check(tag, out0, exp);
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    in0 = 8'h00;
    in1 = 1'b0;
    in2 = 1'b0;
    in3 = 1'b0;
    @(posedge clk);
    #1;
    check("rst_out0", out0, 16'h0000);
    check("rst_out1", {15'd0, out1}, 16'h0000);
    check("rst_out2", {15'd0, out2}, 16'h0000);
    rst = 1'b0;

    // Two records buffered and a run open, then an asynchronous reset mid-cycle
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 8'hA2, 1'b0, 1'b0);
    step(1'b1, 8'hA3, 1'b0, 1'b0);
    check("pre_rst_head", out0, 16'h01A1);
    in1 = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst_out1", {15'd0, out1}, 16'h0000);
    check("async_rst_out0", out0, 16'h0000);
    check("async_rst_out2", {15'd0, out2}, 16'h0000);
    #2;
    rst = 1'b0;
    step(1'b1, 8'h42, 1'b0, 1'b0);
    step(1'b1, 8'h43, 1'b0, 1'b0);
    check("post_rst_rec", out0, 16'h0142);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    check("pop_push_same_edge", out0, 16'h0143);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("drained", {15'd0, out1}, 16'h0000);

    // Three 0x5A then 0x3C with sink ready
    step(1'b1, 8'h5A, 1'b0, 1'b1);
    step(1'b1, 8'h5A, 1'b0, 1'b1);
    step(1'b1, 8'h5A, 1'b0, 1'b1);
    check("run3_empty", {15'd0, out1}, 16'h0000);
    step(1'b1, 8'h3C, 1'b0, 1'b1);
    check("run3_rec", out0, 16'h035A);
    check("run3_valid", {15'd0, out1}, 16'h0001);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("run3_popped", {15'd0, out1}, 16'h0000);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    check("flush_3c", out0, 16'h013C);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("flush_3c_popped", {15'd0, out1}, 16'h0000);

    // 257 words of 0xFF split at MAX_RUN
    for (int i = 1; i <= 257; i++) begin
      step(1'b1, 8'hFF, 1'b0, 1'b0);
      if (i == 255) check("maxrun_no_early_push", {15'd0, out1}, 16'h0000);
      if (i == 256) check("maxrun_split", out0, 16'hFFFF);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    pop_expect("maxrun_rec0", 16'hFFFF);
    pop_expect("maxrun_rec1", 16'h02FF);
    check("maxrun_empty", {15'd0, out1}, 16'h0000);

    // Idle gaps do not close a run
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h01, 1'b0, 1'b0);
    check("gap_no_push", {15'd0, out1}, 16'h0000);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    pop_expect("gap_rec", 16'h0301);
    check("gap_single", {15'd0, out1}, 16'h0000);

    // Full FIFO with pop and push on the same edge
    step(1'b1, 8'h10, 1'b0, 1'b0);
    step(1'b1, 8'h20, 1'b0, 1'b0);
    step(1'b1, 8'h10, 1'b0, 1'b0);
    step(1'b1, 8'h20, 1'b0, 1'b0);
    step(1'b1, 8'h10, 1'b0, 1'b0);
    check("full_head", out0, 16'h0110);
    step(1'b1, 8'h30, 1'b0, 1'b1);
    check("full_popush_head", out0, 16'h0120);
    check("full_popush_ovf", {15'd0, out2}, 16'h0000);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    pop_expect("full_d0", 16'h0120);
    pop_expect("full_d1", 16'h0110);
    pop_expect("full_d2", 16'h0120);
    pop_expect("full_d3", 16'h0110);
    check("full_d_empty", {15'd0, out1}, 16'h0000);

    // flush+en with an equal word starts a fresh run
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    pop_expect("fe_r0", 16'h0130);
    pop_expect("fe_r1", 16'h0277);
    pop_expect("fe_r2", 16'h0177);
    check("fe_empty", {15'd0, out1}, 16'h0000);
    check("fe_ovf", {15'd0, out2}, 16'h0000);

    // Overflow: five pushes into a four-entry FIFO with the sink stalled
    step(1'b1, 8'h10, 1'b0, 1'b0);
    step(1'b1, 8'h20, 1'b0, 1'b0);
    step(1'b1, 8'h10, 1'b0, 1'b0);
    step(1'b1, 8'h20, 1'b0, 1'b0);
    step(1'b1, 8'h10, 1'b0, 1'b0);
    check("ovf_not_yet", {15'd0, out2}, 16'h0000);
    step(1'b1, 8'h20, 1'b0, 1'b0);
    check("ovf_set", {15'd0, out2}, 16'h0001);
    pop_expect("ovf_d0", 16'h0110);
    pop_expect("ovf_d1", 16'h0120);
    pop_expect("ovf_d2", 16'h0110);
    pop_expect("ovf_d3", 16'h0120);
    check("ovf_d_empty", {15'd0, out1}, 16'h0000);
    check("ovf_sticky", {15'd0, out2}, 16'h0001);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    pop_expect("ovf_tail", 16'h0120);
    check("ovf_still_sticky", {15'd0, out2}, 16'h0001);

    rst = 1'b1;
    #1;
    check("ovf_cleared_by_rst", {15'd0, out2}, 16'h0000);
    #2;
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
